// File: rtl/sample_logger_pkg.sv
// sample_logger_pkg
//   Shared definitions for the sample logger.
//   - Default data and address widths, and the memory depth.
//   - The FSM state encoding, which the top module also exposes on its debug port.
package sample_logger_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DEPTH_DEF      = 1 << ADDR_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RD_ISSUE   = 2'd1,
    RD_CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/sample_logger_if.sv
// sample_logger_if
//   Bundles the two sample streams of the logger.
//     s_valid/s_data/s_ready : upstream samples into the logger
//     m_valid/m_data/m_ready : samples out of the logger to the packetizer
//
//   Handshake rule for both streams: a word transfers on a rising edge where
//   valid && ready are both high. A producer that raises valid keeps valid and
//   data stable until that edge. A consumer may drive ready freely.
//
//   Modports:
//     slave  : the logger (consumes s_*, produces m_*)
//     master : the environment (produces s_*, consumes m_*)
interface sample_logger_if #(
  parameter int DW = 8
) ();

  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

endinterface

// File: rtl/sample_logger.sv
// sample_logger
//   Write/read sequencer for a 2**ADDR_WIDTH x DATA_WIDTH single-port sample
//   memory. It is used as a circular FIFO: samples are accepted on the upstream
//   stream, written to memory, read back in order and presented on the
//   downstream stream. At most one memory access is issued per cycle.
//
// Ports
//   clk, rst_n     : clock (rising edge) and asynchronous active-low reset
//   clear          : synchronous flush of pointers, FSM, output word, overflow
//   bus            : upstream/downstream sample streams (slave side)
//   mem_addr       : registered memory address
//   mem_data_in    : registered memory write data
//   mem_write      : registered single-cycle write strobe
//   mem_read       : registered single-cycle read strobe
//   mem_data_out   : memory read data, valid from the edge that samples a read
//   count          : entries held in memory (the output register is not counted)
//   full, empty    : count == DEPTH, count == 0
//   overflow       : sticky, set when a sample is offered while full
//   dbg_state      : current FSM state
module sample_logger
  import sample_logger_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  sample_logger_if.slave        bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output state_t                dbg_state
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(1) << ADDR_WIDTH;

  state_t                state_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic                  last_was_write_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_in_q;
  logic                  mem_write_q;
  logic                  mem_read_q;
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  overflow_q;

  logic [PW-1:0] count_w;
  logic          full_w;
  logic          empty_w;
  logic          want_wr;
  logic          want_rd;
  logic          in_idle;
  logic          do_wr;
  logic          do_rd;

  // The extra pointer bit distinguishes full from empty; the subtraction
  // wraps modulo 2**PW.
  assign count_w = wr_ptr_q - rd_ptr_q;
  assign full_w  = (count_w == DEPTH_P);
  assign empty_w = (count_w == '0);

  // A read is only started when the output register is free, so a word
  // captured from memory never overwrites one still waiting downstream.
  assign want_wr = bus.s_valid && !full_w;
  assign want_rd = !empty_w && !m_valid_q;
  assign in_idle = (state_q == IDLE);

  // When both are wanted, alternate so neither stream can starve the other.
  // clear suppresses the accept so a sample is never taken on a flush edge.
  assign do_wr = in_idle && !clear && want_wr && (!want_rd || !last_was_write_q);
  assign do_rd = in_idle && !clear && want_rd && !do_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      last_was_write_q <= 1'b0;
      mem_addr_q       <= '0;
      mem_data_in_q    <= '0;
      mem_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
      m_valid_q        <= 1'b0;
      m_data_q         <= '0;
      overflow_q       <= 1'b0;
    end else if (clear) begin
      // Memory contents are left alone; an in-flight read is simply dropped.
      state_q          <= IDLE;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      last_was_write_q <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
      m_valid_q        <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses unless re-armed below.
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;

      if (bus.s_valid && full_w) begin
        overflow_q <= 1'b1;
      end

      if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (do_wr) begin
            mem_addr_q       <= wr_ptr_q[ADDR_WIDTH-1:0];
            mem_data_in_q    <= bus.s_data;
            mem_write_q      <= 1'b1;
            wr_ptr_q         <= wr_ptr_q + PW'(1);
            last_was_write_q <= 1'b1;
          end else if (do_rd) begin
            // The word leaves the count as soon as the read is issued.
            mem_addr_q       <= rd_ptr_q[ADDR_WIDTH-1:0];
            mem_read_q       <= 1'b1;
            rd_ptr_q         <= rd_ptr_q + PW'(1);
            last_was_write_q <= 1'b0;
            state_q          <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          // The memory samples the read strobe on this edge.
          state_q <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
          m_data_q  <= mem_data_out;
          m_valid_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready  = do_wr;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_in  = mem_data_in_q;
  assign mem_write    = mem_write_q;
  assign mem_read     = mem_read_q;
  assign count        = count_w;
  assign full         = full_w;
  assign empty        = empty_w;
  assign overflow     = overflow_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sample_logger.sv
// tb_sample_logger
//   Directed bench for sample_logger with a behavioural model of the 16x8
//   sample memory. Samples accepted upstream go into an expected queue and
//   every downstream handshake is checked against its head.
module tb_sample_logger;
  import sample_logger_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  sample_logger_if #(.DW(DW)) bus ();

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic          mem_write;
  logic          mem_read;
  logic [DW-1:0] mem_data_out;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          overflow;
  state_t        dbg_state;

  sample_logger #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .bus          (bus),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_data_out (mem_data_out),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .dbg_state    (dbg_state)
  );

  // Sample memory: a read sampled at an edge drives data_out from that edge
  // until the next read. Contents survive reset and clear.
  logic [DW-1:0] mem_arr [16];
  always @(posedge clk) begin
    if (mem_write) mem_arr[mem_addr] <= mem_data_in;
    if (mem_read)  mem_data_out      <= mem_arr[mem_addr];
  end

  // ---------------- bookkeeping ----------------
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] wa_q  [$];
  int            n_out = 0;
  logic [DW-1:0] last_out = '0;
  bit            en_alt = 0;
  bit            last_op_wr = 0;
  int            alt_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  // Sampled on the falling edge: what is seen here transfers on the next rise.
  always @(negedge clk) begin
    if (rst_n) begin
      check("strobe_excl", 32'(mem_write && mem_read), 32'd0);
      if (mem_write) begin
        wa_q.push_back(mem_addr);
        last_op_wr = 1'b1;
      end
      if (mem_read) last_op_wr = 1'b0;
      if (en_alt && !clear && dbg_state == IDLE && bus.s_valid && !full && !empty && !bus.m_valid) begin
        alt_seen++;
        check("alternate", 32'(bus.s_ready), 32'(!last_op_wr));
      end
      if (!clear) begin
        if (bus.s_valid && bus.s_ready) exp_q.push_back(bus.s_data);
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_extra observed=%0h expected=none", bus.m_data);
          end else begin
            check("sb_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
            n_out++;
            last_out = bus.m_data;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("push_accept", 32'(ok), 32'd1);
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (count == 0 && !bus.m_valid && dbg_state == IDLE && !mem_write && !mem_read) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
    last_op_wr = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int n0;

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;

    // Reset values while rst_n is held low
    repeat (3) @(posedge clk);
    #1;
    check("rst_count",    32'(count),        32'd0);
    check("rst_empty",    32'(empty),        32'd1);
    check("rst_full",     32'(full),         32'd0);
    check("rst_overflow", 32'(overflow),     32'd0);
    check("rst_m_valid",  32'(bus.m_valid),  32'd0);
    check("rst_m_data",   32'(bus.m_data),   32'd0);
    check("rst_mem_wr",   32'(mem_write),    32'd0);
    check("rst_mem_rd",   32'(mem_read),     32'd0);
    check("rst_mem_addr", 32'(mem_addr),     32'd0);
    check("rst_state",    32'(dbg_state),    32'(IDLE));
    #2 rst_n = 1'b1;
    tick();

    // 1: three samples, downstream always ready
    bus.m_ready = 1'b1;
    wa_q.delete();
    n0 = n_out;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    drain("t1_drain");
    check("t1_nout",  32'(n_out - n0),  32'd3);
    check("t1_nwr",   32'(wa_q.size()), 32'd3);
    check("t1_addr0", 32'(wa_q[0]),     32'd0);
    check("t1_addr1", 32'(wa_q[1]),     32'd1);
    check("t1_addr2", 32'(wa_q[2]),     32'd2);
    check("t1_last",  32'(last_out),    32'h33);
    check("t1_count", 32'(count),       32'd0);
    check("t1_empty", 32'(empty),       32'd1);

    // 2: fill with downstream stalled. The first sample moves into the
    // output register, so 17 samples are needed for 16 entries in memory.
    bus.m_ready = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 17; i++) push(8'(i));
    check("t2_full",  32'(full),  32'd1);
    check("t2_count", 32'(count), 32'd16);
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hEE;
    #1;
    check("t2_s_ready_full", 32'(bus.s_ready), 32'd0);
    check("t2_ovf_before",   32'(overflow),    32'd0);
    tick();
    check("t2_overflow",    32'(overflow), 32'd1);
    check("t2_still_full",  32'(count),    32'd16);
    bus.s_valid = 1'b0;
    drain("t2_drain");
    check("t2_nout",     32'(n_out - n0), 32'd17);
    check("t2_last",     32'(last_out),   32'h10);
    check("t2_ovf_kept", 32'(overflow),   32'd1);

    // 3: wrap-around of the memory address
    do_clear();
    check("t3_ovf_clr", 32'(overflow), 32'd0);
    check("t3_count",   32'(count),    32'd0);
    for (int i = 0; i < 10; i++) push(8'h30 + 8'(i));
    drain("t3_drain_a");
    wa_q.delete();
    n0 = n_out;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i));
    drain("t3_drain_b");
    check("t3_nwr", 32'(wa_q.size()), 32'd10);
    for (int i = 0; i < 10; i++) check($sformatf("t3_addr%0d", i), 32'(wa_q[i]), 32'((10 + i) % 16));
    check("t3_nout", 32'(n_out - n0), 32'd10);
    check("t3_last", 32'(last_out),   32'hA9);

    // 4: continuous traffic, alternation and no loss/duplication
    do_clear();
    en_alt = 1'b1;
    alt_seen = 0;
    n0 = n_out;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 64; i++) push(8'(i * 7 + 3));
    drain("t4_drain");
    en_alt = 1'b0;
    check("t4_nout",     32'(n_out - n0),    32'd64);
    check("t4_alt_seen", 32'(alt_seen != 0), 32'd1);

    // 5: clear while a read is being issued with 5 entries left
    do_clear();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 7; i++) push(8'h50 + 8'(i));
    check("t5_count6", 32'(count),     32'd6);
    check("t5_mvalid", 32'(bus.m_valid), 32'd1);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (dbg_state == RD_ISSUE) begin
          ok = 1'b1;
          break;
        end
      end
      check("t5_reach_issue", 32'(ok), 32'd1);
    end
    check("t5_count5",  32'(count),    32'd5);
    check("t5_rd_high", 32'(mem_read), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
    last_op_wr = 1'b0;
    check("t5_clr_count", 32'(count),       32'd0);
    check("t5_clr_mval",  32'(bus.m_valid), 32'd0);
    check("t5_clr_rd",    32'(mem_read),    32'd0);
    check("t5_clr_ovf",   32'(overflow),    32'd0);
    check("t5_clr_state", 32'(dbg_state),   32'(IDLE));
    n0 = n_out;
    bus.m_ready = 1'b1;
    push(8'h5A);
    drain("t5_drain");
    check("t5_nout", 32'(n_out - n0), 32'd1);
    check("t5_last", 32'(last_out),   32'h5A);

    // 6: asynchronous reset during RD_CAPTURE
    bus.m_ready = 1'b0;
    push(8'h66);
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (dbg_state == RD_CAPTURE) begin
          ok = 1'b1;
          break;
        end
      end
      check("t6_reach_capture", 32'(ok), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("t6_state",    32'(dbg_state),   32'(IDLE));
    check("t6_mval",     32'(bus.m_valid), 32'd0);
    check("t6_mdata",    32'(bus.m_data),  32'd0);
    check("t6_rd",       32'(mem_read),    32'd0);
    check("t6_wr",       32'(mem_write),   32'd0);
    check("t6_addr",     32'(mem_addr),    32'd0);
    check("t6_count",    32'(count),       32'd0);
    check("t6_empty",    32'(empty),       32'd1);
    check("t6_full",     32'(full),        32'd0);
    check("t6_overflow", 32'(overflow),    32'd0);
    exp_q.delete();
    last_op_wr = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    wa_q.delete();
    n0 = n_out;
    bus.m_ready = 1'b1;
    push(8'h77);
    push(8'h88);
    drain("t6_drain");
    check("t6_nout",  32'(n_out - n0),  32'd2);
    check("t6_addr0", 32'(wa_q[0]),     32'd0);
    check("t6_addr1", 32'(wa_q[1]),     32'd1);
    check("t6_last",  32'(last_out),    32'h88);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
